// File: rtl/vram_console_pkg.sv
// Shared encodings for the text-console sequencer: command opcodes,
// special cell values, control characters and the sequencer state set.
package vram_console_pkg;

    typedef enum logic [1:0] {
        OP_PUTC   = 2'd0,
        OP_CLEAR  = 2'd1,
        OP_SETPOS = 2'd2,
        OP_NOP    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ERASE    = 3'd1,
        ST_PUT      = 3'd2,
        ST_SCR_RD   = 3'd3,
        ST_SCR_WR   = 3'd4,
        ST_SCR_FILL = 3'd5,
        ST_CLR      = 3'd6,
        ST_GLYPH    = 3'd7
    } state_e;

    localparam logic [15:0] BLANK        = 16'h0020;
    localparam logic [15:0] CURSOR_GLYPH = 16'h025F;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;

    // Row-to-base-address conversion as a shift-and-add over the row bits,
    // only used when the cursor jumps to an arbitrary row.
    function automatic logic [15:0] mul_cols(input logic [7:0] row, input logic [15:0] cols);
        logic [15:0] acc;
        acc = 16'd0;
        for (int i = 0; i < 8; i++) begin
            if (row[i]) begin
                acc = acc + (cols << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vram_console_ctrl.sv
// Text-console sequencer driving port A of the video RAM: character writes,
// cursor glyph placement, full-screen clear and one-row scroll.
module vram_console_ctrl
    import vram_console_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [15:0]       cmd_data,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [15:0]       vram_wdata,
    output logic              vram_we,
    input  logic [15:0]       vram_q,
    output logic [7:0]        cur_row,
    output logic [7:0]        cur_col,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_SRC  = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
    localparam logic [7:0]        LAST_ROW  = 8'(ROWS - 1);

    state_e            state_q, state_d;
    logic [7:0]        row_q, row_d;
    logic [7:0]        col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [15:0]       data_q, data_d;

    logic [ADDR_W-1:0] cursor_addr_s;
    logic [7:0]        set_row_s;
    logic [7:0]        set_col_s;

    assign cursor_addr_s = base_q + ADDR_W'(col_q);
    assign cmd_ready     = (state_q == ST_IDLE);
    assign busy          = ~cmd_ready;
    assign cur_row       = row_q;
    assign cur_col       = col_q;

    // Clamp a requested SETPOS position onto the visible screen.
    always_comb begin
        set_row_s = data_q[15:8];
        set_col_s = data_q[7:0];
        if (data_q[15:8] > LAST_ROW) begin
            set_row_s = LAST_ROW;
        end else begin
            set_row_s = data_q[15:8];
        end
        if (data_q[7:0] > LAST_COL) begin
            set_col_s = LAST_COL;
        end else begin
            set_col_s = data_q[7:0];
        end
    end

    // State, cursor and counter registers; reset leaves RAM contents alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= 8'd0;
            col_q   <= 8'd0;
            base_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            data_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: command decode, cursor movement and scroll/clear sweeps.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = op_e'(cmd_op);
                    data_d = cmd_data;
                    case (op_e'(cmd_op))
                        OP_PUTC: begin
                            if ((cmd_data[7:0] == CH_LF) || (cmd_data[7:0] == CH_CR)) begin
                                state_d = ST_ERASE;
                            end else if (cmd_data[7:0] == CH_BS) begin
                                // Backspace at column 0 only redraws the cursor.
                                if (col_q != 8'd0) begin
                                    state_d = ST_ERASE;
                                end else begin
                                    state_d = ST_GLYPH;
                                end
                            end else begin
                                state_d = ST_PUT;
                            end
                        end
                        OP_CLEAR: begin
                            row_d   = 8'd0;
                            col_d   = 8'd0;
                            base_d  = '0;
                            cnt_d   = '0;
                            state_d = ST_CLR;
                        end
                        OP_SETPOS: begin
                            state_d = ST_ERASE;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUT: begin
                if (col_q == LAST_COL) begin
                    col_d = 8'd0;
                    if (row_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = ST_SCR_RD;
                    end else begin
                        row_d   = row_q + 8'd1;
                        base_d  = base_q + COLS_A;
                        state_d = ST_GLYPH;
                    end
                end else begin
                    col_d   = col_q + 8'd1;
                    state_d = ST_GLYPH;
                end
            end
            ST_ERASE: begin
                state_d = ST_GLYPH;
                if (op_q == OP_SETPOS) begin
                    row_d  = set_row_s;
                    col_d  = set_col_s;
                    base_d = ADDR_W'(mul_cols(set_row_s, 16'(COLS)));
                end else begin
                    case (data_q[7:0])
                        CH_LF: begin
                            col_d = 8'd0;
                            if (row_q == LAST_ROW) begin
                                cnt_d   = '0;
                                state_d = ST_SCR_RD;
                            end else begin
                                row_d  = row_q + 8'd1;
                                base_d = base_q + COLS_A;
                            end
                        end
                        CH_CR: begin
                            col_d = 8'd0;
                        end
                        CH_BS: begin
                            col_d = col_q - 8'd1;
                        end
                        default: begin
                            col_d = col_q;
                        end
                    endcase
                end
            end
            ST_SCR_RD: begin
                state_d = ST_SCR_WR;
            end
            ST_SCR_WR: begin
                cnt_d = cnt_q + ONE_A;
                if (cnt_q == LAST_SRC) begin
                    state_d = ST_SCR_FILL;
                end else begin
                    state_d = ST_SCR_RD;
                end
            end
            ST_SCR_FILL, ST_CLR: begin
                if (cnt_q == LAST_CELL) begin
                    state_d = ST_GLYPH;
                end else begin
                    cnt_d = cnt_q + ONE_A;
                end
            end
            ST_GLYPH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Port-A decode from registered state; idle drives all-zero, no write.
    always_comb begin
        vram_addr  = '0;
        vram_wdata = 16'd0;
        vram_we    = 1'b0;
        case (state_q)
            ST_PUT: begin
                vram_addr  = cursor_addr_s;
                vram_wdata = data_q;
                vram_we    = 1'b1;
            end
            ST_ERASE: begin
                vram_addr  = cursor_addr_s;
                vram_wdata = BLANK;
                vram_we    = 1'b1;
            end
            ST_SCR_RD: begin
                vram_addr = cnt_q + COLS_A;
            end
            ST_SCR_WR: begin
                vram_addr  = cnt_q;
                vram_wdata = vram_q;
                vram_we    = 1'b1;
            end
            ST_SCR_FILL, ST_CLR: begin
                vram_addr  = cnt_q;
                vram_wdata = BLANK;
                vram_we    = 1'b1;
            end
            ST_GLYPH: begin
                vram_addr  = cursor_addr_s;
                vram_wdata = CURSOR_GLYPH;
                vram_we    = 1'b1;
            end
            default: begin
                vram_addr  = '0;
                vram_wdata = 16'd0;
                vram_we    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vram_console_ctrl.sv
// Directed bench for vram_console_ctrl with a behavioural port-A RAM model.
module tb_vram_console_ctrl;

    localparam int ADDR_W = 11;
    localparam int LOG_N  = 8192;
    localparam int LIMIT  = 5000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd3;
    logic [15:0]       cmd_data = 16'd0;
    logic [ADDR_W-1:0] vram_addr;
    logic [15:0]       vram_wdata;
    logic              vram_we;
    logic [15:0]       vram_q = 16'd0;
    logic [7:0]        cur_row;
    logic [7:0]        cur_col;
    logic              busy;

    logic [15:0]       mem [0:2047];
    logic [15:0]       pre [0:2047];
    logic [ADDR_W-1:0] log_a [0:LOG_N-1];
    logic [15:0]       log_d [0:LOG_N-1];
    logic              lat_we = 1'b0;
    logic [ADDR_W-1:0] lat_addr = '0;
    logic [15:0]       lat_wdata = 16'd0;
    int                wr_count = 0;
    int                wr_start = 0;
    int                tests = 0;
    int                fails = 0;
    int                n;
    int                bad;
    int                snap;

    vram_console_ctrl #(.COLS(80), .ROWS(25), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .vram_q     (vram_q),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    // Capture port A mid-cycle so the RAM model never races the DUT registers.
    always @(negedge clk) begin
        lat_we    = vram_we;
        lat_addr  = vram_addr;
        lat_wdata = vram_wdata;
    end

    // Synchronous RAM: registered read of the old contents, logged writes.
    always @(posedge clk) begin
        vram_q <= mem[lat_addr];
        if (lat_we) begin
            mem[lat_addr] = lat_wdata;
            if (wr_count < LOG_N) begin
                log_a[wr_count] = lat_addr;
                log_d[wr_count] = lat_wdata;
            end
            wr_count++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int k, input int a, input int d);
        check_eq({tag, "_addr"}, 32'(log_a[(wr_start + k) % LOG_N]), 32'(a));
        check_eq({tag, "_data"}, 32'(log_d[(wr_start + k) % LOG_N]), 32'(d));
    endtask

    task automatic check_cur(input string tag, input int r, input int c);
        check_eq({tag, "_row"}, 32'(cur_row), 32'(r));
        check_eq({tag, "_col"}, 32'(cur_col), 32'(c));
    endtask

    // Issue one command and count the cycles cmd_ready stays low afterwards.
    task automatic send_cmd(input logic [1:0] op, input logic [15:0] data, output int cyc);
        @(negedge clk);
        check_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
        wr_start  = wr_count;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
        cmd_data  = 16'd0;
        cyc = 0;
        while (!cmd_ready && cyc < LIMIT) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        check_eq("busy_bounded", 32'(cyc < LIMIT), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 16'(i) ^ 16'h5A00;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_we", 32'(vram_we), 32'd0);
        check_eq("rst_addr", 32'(vram_addr), 32'd0);
        check_eq("rst_wdata", 32'(vram_wdata), 32'd0);
        check_cur("rst_cur", 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Printable character at home position.
        send_cmd(2'd0, 16'h0057, n);
        check_eq("putc_n", 32'(n), 32'd2);
        check_eq("putc_nwr", 32'(wr_count - wr_start), 32'd2);
        check_wr("putc_w0", 0, 0, 16'h0057);
        check_wr("putc_w1", 1, 1, 16'h025F);
        check_cur("putc_cur", 0, 1);

        // Last column wraps to the next row.
        send_cmd(2'd2, 16'h004F, n);
        check_eq("setpos_n", 32'(n), 32'd2);
        check_wr("setpos_erase", 0, 1, 16'h0020);
        check_wr("setpos_glyph", 1, 79, 16'h025F);
        send_cmd(2'd0, 16'h0041, n);
        check_eq("wrap_n", 32'(n), 32'd2);
        check_wr("wrap_w0", 0, 79, 16'h0041);
        check_wr("wrap_w1", 1, 80, 16'h025F);
        check_cur("wrap_cur", 1, 0);

        // Line feed on the last row scrolls the screen.
        send_cmd(2'd2, 16'h1805, n);
        check_wr("setpos2_glyph", 1, 1925, 16'h025F);
        for (int i = 0; i < 2048; i++) begin
            pre[i] = mem[i];
        end
        send_cmd(2'd0, 16'h000A, n);
        check_eq("lf_scroll_n", 32'(n), 32'd3922);
        check_eq("lf_scroll_nwr", 32'(wr_count - wr_start), 32'd2002);
        check_wr("lf_erase", 0, 1925, 16'h0020);
        check_wr("lf_glyph", 2001, 1920, 16'h025F);
        bad = 0;
        for (int a = 0; a < 1920; a++) begin
            if (mem[a] !== ((a + 80 == 1925) ? 16'h0020 : pre[a + 80])) bad++;
        end
        check_eq("scroll_copy_bad", 32'(bad), 32'd0);
        bad = 0;
        for (int a = 1921; a < 2000; a++) begin
            if (mem[a] !== 16'h0020) bad++;
        end
        check_eq("scroll_fill_bad", 32'(bad), 32'd0);
        check_eq("scroll_glyph_mem", 32'(mem[1920]), 32'h025F);
        check_cur("lf_cur", 24, 0);

        // Backspace at column 0 only redraws the cursor.
        send_cmd(2'd2, 16'h0300, n);
        check_wr("setpos3_erase", 0, 1920, 16'h0020);
        send_cmd(2'd0, 16'h0008, n);
        check_eq("bs0_n", 32'(n), 32'd1);
        check_eq("bs0_nwr", 32'(wr_count - wr_start), 32'd1);
        check_wr("bs0_glyph", 0, 240, 16'h025F);
        check_cur("bs0_cur", 3, 0);

        // Out-of-range SETPOS clamps to the bottom-right cell.
        send_cmd(2'd2, 16'h1E5A, n);
        check_eq("clamp_n", 32'(n), 32'd2);
        check_wr("clamp_glyph", 1, 1999, 16'h025F);
        check_cur("clamp_cur", 24, 79);

        // NOP is absorbed without leaving idle.
        send_cmd(2'd3, 16'h1234, n);
        check_eq("nop_n", 32'(n), 32'd0);
        check_eq("nop_nwr", 32'(wr_count - wr_start), 32'd0);

        // Printable at the last cell wraps and scrolls.
        send_cmd(2'd0, 16'h0043, n);
        check_eq("put_scroll_n", 32'(n), 32'd3922);
        check_wr("put_scroll_w0", 0, 1999, 16'h0043);
        check_wr("put_scroll_glyph", 2001, 1920, 16'h025F);
        check_eq("put_scroll_moved", 32'(mem[1919]), 32'h0043);
        check_cur("put_scroll_cur", 24, 0);

        // Full clear.
        send_cmd(2'd1, 16'h0000, n);
        check_eq("clr_n", 32'(n), 32'd2001);
        check_eq("clr_nwr", 32'(wr_count - wr_start), 32'd2001);
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            if (log_a[(wr_start + k) % LOG_N] !== 11'(k) || log_d[(wr_start + k) % LOG_N] !== 16'h0020) bad++;
        end
        check_eq("clr_seq_bad", 32'(bad), 32'd0);
        check_wr("clr_glyph", 2000, 0, 16'h025F);
        check_cur("clr_cur", 0, 0);

        // Clear interrupted by reset around its 500th write.
        send_cmd(2'd2, 16'h0202, n);
        check_cur("pre_rst_cur", 2, 2);
        @(negedge clk);
        wr_start  = wr_count;
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_data  = 16'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
        n = 0;
        while ((wr_count - wr_start) < 499 && n < LIMIT) begin
            n++;
            @(posedge clk);
            #1;
        end
        check_eq("rst_run_reached", 32'(n < LIMIT), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_we", 32'(vram_we), 32'd0);
        check_eq("midrst_addr", 32'(vram_addr), 32'd0);
        check_eq("midrst_ready", 32'(cmd_ready), 32'd1);
        check_cur("midrst_cur", 0, 0);
        snap = wr_count;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_no_writes", 32'(wr_count - snap), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
        check_cur("post_rst_cur", 0, 0);
        send_cmd(2'd0, 16'h0058, n);
        check_eq("post_rst_putc_n", 32'(n), 32'd2);
        check_wr("post_rst_w0", 0, 0, 16'h0058);
        check_wr("post_rst_w1", 1, 1, 16'h025F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
